reg_file: RTL and testbench

- Multi-ported general-purpose register file for the CPU datapath.
- 2^ADDR_W words of DATA_W bits, with one synchronous write port and two asynchronous (combinational) read ports.
- Sits between decode (read addresses) and writeback (write port).

---
 rtl/reg_file_pkg.sv | 17 +
 rtl/reg_file_if.sv | 30 +++
 rtl/reg_file_rd_port.sv | 20 ++
 rtl/reg_file.sv | 54 +++++
 tb/tb_reg_file.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the general-purpose register file.
// Other files size themselves from these values by default.
package reg_file_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // True when an access to this address must behave as the hardwired zero register.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr, input int zero_reg);
    return (zero_reg != 0) && (addr == '0);
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Register file bus: one write strobe port and two combinational read ports.
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
);

  // No valid/ready pair: the write is a single-cycle strobe. When we is high at a
  // rising clk (reset released), wdata lands in waddr at that edge; reads are
  // pure combinational lookups of raddr1/raddr2 with no handshake at all.
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;

  modport master (
    output we, waddr, wdata, raddr1, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2,
    output rdata1, rdata2
  );

endinterface

// File: rtl/reg_file_rd_port.sv
// One combinational read port: selects a word from storage, forcing zero
// for address 0 when the zero register is hardwired.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = reg_file_pkg::DATA_W,
  parameter int ADDR_W   = reg_file_pkg::ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic [DATA_W-1:0] i_mem [1 << ADDR_W],
  output logic [DATA_W-1:0] o_rdata
);

  logic w_force_zero;

  assign w_force_zero = is_zero_reg(i_raddr, ZERO_REG);
  assign o_rdata      = w_force_zero ? '0 : i_mem[i_raddr];

endmodule

// File: rtl/reg_file.sv
// General-purpose register file: one synchronous write port, two asynchronous
// read ports, asynchronous active-low clear of all storage.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = reg_file_pkg::DATA_W,
  parameter int ADDR_W   = reg_file_pkg::ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_if.slave    bus
);

  localparam int NUM = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [NUM];
  logic              w_wr_en;

  // Writes to a hardwired zero register are dropped so storage stays clean.
  assign w_wr_en = bus.we && !is_zero_reg(bus.waddr, ZERO_REG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[bus.waddr] <= bus.wdata;
    end
  end

  // No write-through bypass: a same-cycle read sees the old word until the edge.
  reg_file_rd_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rd_port1 (
    .i_raddr (bus.raddr1),
    .i_mem   (r_mem),
    .o_rdata (bus.rdata1)
  );

  reg_file_rd_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rd_port2 (
    .i_raddr (bus.raddr2),
    .i_mem   (r_mem),
    .o_rdata (bus.rdata2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: two instances (zero register hardwired / ordinary)
// driven in lockstep, expected words queued at drive time and popped at sample time.
`timescale 1ns/100ps
module tb_reg_file;
  import reg_file_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  we;
  addr_t waddr;
  word_t wdata;
  addr_t raddr1;
  addr_t raddr2;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_q[$];
  word_t m0 [NUM_REGS];
  word_t m1 [NUM_REGS];

  reg_file_if bus0 ();
  reg_file_if bus1 ();

  assign bus0.we     = we;
  assign bus0.waddr  = waddr;
  assign bus0.wdata  = wdata;
  assign bus0.raddr1 = raddr1;
  assign bus0.raddr2 = raddr2;
  assign bus1.we     = we;
  assign bus1.waddr  = waddr;
  assign bus1.wdata  = wdata;
  assign bus1.raddr1 = raddr1;
  assign bus1.raddr2 = raddr2;

  reg_file #(.ZERO_REG(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  reg_file #(.ZERO_REG(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Clock / reset
  always #5 clk = ~clk;

  task automatic clear_model();
    for (int i = 0; i < NUM_REGS; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end
  endtask

  // Scoreboard compare
  task automatic chk(input string tag, input word_t obs);
    word_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s no expected value queued, got %h", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, obs, e);
    end
  endtask

  // Drivers
  task automatic do_write(input addr_t a, input word_t d);
    @(negedge clk);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    @(posedge clk);
    if (rst_n) begin
      if (a != 0) m0[a] = d;
      m1[a] = d;
    end
    #1;
    we = 1'b0;
  endtask

  task automatic read_pair(input string tag, input addr_t a1, input addr_t a2);
    raddr1 = a1;
    raddr2 = a2;
    exp_q.push_back(m0[a1]);
    exp_q.push_back(m0[a2]);
    exp_q.push_back(m1[a1]);
    exp_q.push_back(m1[a2]);
    #1;
    chk({tag, "_z1_rd1"}, bus0.rdata1);
    chk({tag, "_z1_rd2"}, bus0.rdata2);
    chk({tag, "_z0_rd1"}, bus1.rdata1);
    chk({tag, "_z0_rd2"}, bus1.rdata2);
  endtask

  initial begin
    rst_n  = 1'b0;
    we     = 1'b0;
    waddr  = '0;
    wdata  = '0;
    raddr1 = '0;
    raddr2 = '0;
    clear_model();
    #2;
    read_pair("rst_init", 5'd0, 5'd31);
    read_pair("rst_init", 5'd10, 5'd20);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write then same-cycle combinational read
    do_write(5'd10, 32'd10);
    do_write(5'd20, 32'd20);
    read_pair("basic", 5'd10, 5'd20);

    // we low must not disturb contents
    @(negedge clk);
    we    = 1'b0;
    waddr = 5'd10;
    wdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    read_pair("we_low", 5'd10, 5'd20);

    // Read-after-write on the same address: old before the edge, new after
    do_write(5'd7, 32'h11);
    @(negedge clk);
    raddr1 = 5'd7;
    raddr2 = 5'd7;
    we     = 1'b1;
    waddr  = 5'd7;
    wdata  = 32'h22;
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h11);
    #1;
    chk("raw_pre_z1", bus0.rdata1);
    chk("raw_pre_z0", bus1.rdata2);
    @(posedge clk);
    m0[7] = 32'h22;
    m1[7] = 32'h22;
    #1;
    we = 1'b0;
    read_pair("raw_post", 5'd7, 5'd7);

    // Zero register: discarded when hardwired, stored otherwise
    do_write(5'd0, 32'hFFFF_FFFF);
    read_pair("zero_reg", 5'd0, 5'd0);
    exp_q.push_back(32'hFFFF_FFFF);
    chk("zero_reg_z0_const", bus1.rdata1);

    // Full sweep with opposing port addresses
    for (int i = 0; i < NUM_REGS; i++) begin
      do_write(addr_t'(i), 32'(i) * 32'h0101_0101);
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      read_pair("sweep", addr_t'(i), addr_t'(NUM_REGS - 1 - i));
    end
    exp_q.push_back(32'h1F1F_1F1F);
    chk("sweep_top_const", bus0.rdata1);

    // Mid-simulation asynchronous reset, checked before any clock edge
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    clear_model();
    read_pair("async_rst", 5'd31, 5'd15);
    for (int i = 0; i < NUM_REGS; i++) begin
      read_pair("rst_sweep", addr_t'(i), addr_t'(NUM_REGS - 1 - i));
    end

    // Writes while reset is held are ignored
    do_write(5'd5, 32'hAAAA_5555);
    read_pair("wr_in_rst", 5'd5, 5'd5);
    @(negedge clk);
    rst_n = 1'b1;
    do_write(5'd5, 32'h1234_5678);
    read_pair("post_rst", 5'd5, 5'd0);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover got %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
